// File: rtl/sdram_frame_arbiter.sv
// Arbitrates the SDRAM command engine between refresh, camera write bursts and VGA read bursts,
// and owns the ping-pong frame pointers. One-cycle decision latency; each command is held until acked.
module sdram_frame_arbiter #(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 307200,
  parameter int REF_PERIOD  = 780,
  parameter int ADDR_W      = 24,
  parameter int LVL_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_done,
  input  logic [LVL_W-1:0]  i_wr_level,
  input  logic [LVL_W-1:0]  i_rd_space,
  input  logic              i_wr_frame_start,
  input  logic              i_rd_frame_start,
  output logic              o_cmd_req,
  output logic [1:0]        o_cmd_type,
  output logic [ADDR_W-1:0] o_cmd_addr,
  input  logic              i_cmd_ack,
  input  logic              i_cmd_done,
  output logic              o_wr_flush,
  output logic              o_frame_valid,
  output logic              o_ref_overrun
);

  localparam int OFF_W = ADDR_W - 1;
  localparam int REF_W = $clog2(REF_PERIOD);

  localparam logic [1:0] T_REF = 2'b00;
  localparam logic [1:0] T_WR  = 2'b01;
  localparam logic [1:0] T_RD  = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [LVL_W-1:0] L_BURST    = LVL_W'(BURST_LEN);
  localparam logic [OFF_W-1:0] L_STEP     = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0] L_FRAME    = OFF_W'(FRAME_WORDS);
  localparam logic [REF_W-1:0] L_REF_LAST = REF_W'(REF_PERIOD - 1);

  logic [1:0]        r_state;
  logic [REF_W-1:0]  r_ref_cnt;
  logic              r_ref_pend;
  logic              r_ref_overrun;
  logic              r_wr_buf;
  logic              r_rd_buf;
  logic [OFF_W-1:0]  r_wr_ptr;
  logic [OFF_W-1:0]  r_rd_ptr;
  logic              r_last_rd;
  logic              r_wr_fs_pend;
  logic              r_rd_fs_pend;
  logic              r_cmd_req;
  logic [1:0]        r_cmd_type;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic              r_wr_flush;
  logic              r_frame_valid;

  logic w_ref_wrap;
  logic w_ref_ack;
  logic w_wr_elig;
  logic w_rd_elig;
  logic w_apply;
  logic w_pick_wr;
  logic w_wr_buf_nx;

  assign w_ref_wrap  = i_init_done && (r_ref_cnt == L_REF_LAST);
  assign w_ref_ack   = (r_state == S_ISSUE) && i_cmd_ack && (r_cmd_type == T_REF);
  assign w_wr_elig   = (i_wr_level >= L_BURST) && (r_wr_ptr < L_FRAME);
  assign w_rd_elig   = (i_rd_space >= L_BURST) && (r_rd_ptr < L_FRAME);
  assign w_apply     = (r_state == S_IDLE) && (r_wr_fs_pend || r_rd_fs_pend);
  assign w_pick_wr   = w_wr_elig && (!w_rd_elig || r_last_rd);
  // A pending read frame start must see the buffer chosen by a simultaneous write frame start.
  assign w_wr_buf_nx = (r_wr_fs_pend && (r_wr_ptr == L_FRAME)) ? ~r_wr_buf : r_wr_buf;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_cnt     <= '0;
      r_ref_pend    <= 1'b0;
      r_ref_overrun <= 1'b0;
    end else begin
      if (i_init_done) r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + REF_W'(1);
      r_ref_pend <= w_ref_wrap | (r_ref_pend & ~w_ref_ack);
      if (w_ref_wrap && r_ref_pend && !w_ref_ack) r_ref_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_fs_pend <= 1'b0;
      r_rd_fs_pend <= 1'b0;
    end else begin
      r_wr_fs_pend <= i_wr_frame_start | (r_wr_fs_pend & ~w_apply);
      r_rd_fs_pend <= i_rd_frame_start | (r_rd_fs_pend & ~w_apply);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wr_buf      <= 1'b0;
      r_rd_buf      <= 1'b1;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_last_rd     <= 1'b1;
      r_cmd_req     <= 1'b0;
      r_cmd_type    <= T_REF;
      r_cmd_addr    <= '0;
      r_wr_flush    <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_wr_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_apply) begin
            if (r_wr_fs_pend) begin
              r_wr_buf   <= w_wr_buf_nx;
              r_wr_ptr   <= '0;
              r_wr_flush <= 1'b1;
              if (r_wr_ptr == L_FRAME) r_frame_valid <= 1'b1;
            end
            if (r_rd_fs_pend) begin
              r_rd_buf <= ~w_wr_buf_nx;
              r_rd_ptr <= '0;
            end
          end else if (i_init_done) begin
            if (r_ref_pend) begin
              r_cmd_req  <= 1'b1;
              r_cmd_type <= T_REF;
              r_cmd_addr <= '0;
              r_state    <= S_ISSUE;
            end else if (w_wr_elig || w_rd_elig) begin
              r_cmd_req  <= 1'b1;
              r_cmd_type <= w_pick_wr ? T_WR : T_RD;
              r_cmd_addr <= w_pick_wr ? {r_wr_buf, r_wr_ptr} : {r_rd_buf, r_rd_ptr};
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (i_cmd_ack) begin
            r_cmd_req <= 1'b0;
            r_state   <= S_BUSY;
            if (r_cmd_type == T_WR) r_last_rd <= 1'b0;
            else if (r_cmd_type == T_RD) r_last_rd <= 1'b1;
          end
        end
        S_BUSY: begin
          if (i_cmd_done) begin
            r_state <= S_IDLE;
            if (r_cmd_type == T_WR) r_wr_ptr <= r_wr_ptr + L_STEP;
            else if (r_cmd_type == T_RD) r_rd_ptr <= r_rd_ptr + L_STEP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_req     = r_cmd_req;
  assign o_cmd_type    = r_cmd_type;
  assign o_cmd_addr    = r_cmd_addr;
  assign o_wr_flush    = r_wr_flush;
  assign o_frame_valid = r_frame_valid;
  assign o_ref_overrun = r_ref_overrun;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter: vector table for single-decision cases, plus a command
// scoreboard fed by a simple engine model for the multi-cycle sequences.
module tb_sdram_frame_arbiter;
  localparam int ADDR_W = 24;
  localparam int LVL_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done;
  logic [LVL_W-1:0]  wr_level;
  logic [LVL_W-1:0]  rd_space;
  logic              wr_fs;
  logic              rd_fs;
  logic              cmd_req;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ack;
  logic              cmd_done;
  logic              wr_flush;
  logic              frame_valid;
  logic              ref_overrun;

  sdram_frame_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
    .i_wr_level(wr_level), .i_rd_space(rd_space),
    .i_wr_frame_start(wr_fs), .i_rd_frame_start(rd_fs),
    .o_cmd_req(cmd_req), .o_cmd_type(cmd_type), .o_cmd_addr(cmd_addr),
    .i_cmd_ack(cmd_ack), .i_cmd_done(cmd_done),
    .o_wr_flush(wr_flush), .o_frame_valid(frame_valid), .o_ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int flush_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (wr_flush) flush_cnt <= flush_cnt + 1;

  typedef struct packed { logic [1:0] t; logic [ADDR_W-1:0] a; } cmd_t;
  typedef struct { logic [9:0] wl; logic [9:0] rs; logic req; logic [1:0] t; logic [23:0] a; } vec_t;

  cmd_t exp_q[$];
  int   ref_t[$];
  cmd_t eng_got, eng_exp;
  vec_t vt[7];
  int   n_err = 0, n_chk = 0, n_sb = 0;
  bit   ack_en = 0, ign_ref = 0;
  int   done_dly = 0;
  int   c0, fc0, stab_err, k;
  logic [25:0] held;

  task check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_sb(input int target, input int budget, input string name);
    int t0 = cyc;
    while (n_sb < target && (cyc - t0) < budget) @(negedge clk);
    n_chk++;
    if (n_sb < target) begin
      n_err++;
      $display("FAIL %s: timeout, got %0d commands expected %0d", name, n_sb, target);
    end
  endtask

  task do_reset();
    rst = 1'b1; ack_en = 0; ign_ref = 0; done_dly = 0;
    init_done = 1'b0; wr_level = '0; rd_space = '0; wr_fs = 1'b0; rd_fs = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete(); ref_t.delete(); n_sb = 0;
    rst = 1'b0;
  endtask

  task pulse_wr();
    @(negedge clk); wr_fs = 1'b1;
    @(negedge clk); wr_fs = 1'b0;
  endtask

  task pulse_rd();
    @(negedge clk); rd_fs = 1'b1;
    @(negedge clk); rd_fs = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; wr_level = '0; rd_space = '0;
    wr_fs = 1'b0; rd_fs = 1'b0; cmd_ack = 1'b0; cmd_done = 1'b0;

    fork
      begin : engine
        forever begin
          @(negedge clk);
          if (!rst && ack_en && cmd_req) begin
            eng_got = {cmd_type, cmd_addr};
            cmd_ack = 1'b1;
            if (eng_got.t == 2'b00) ref_t.push_back(cyc);
            if (!(ign_ref && eng_got.t == 2'b00)) begin
              n_sb++;
              if (exp_q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL sb_unexpected: got cmd %0h with nothing expected", eng_got);
              end else begin
                eng_exp = exp_q.pop_front();
                check("sb_cmd", 64'(eng_got), 64'(eng_exp));
              end
            end
            @(negedge clk); cmd_ack = 1'b0;
            repeat (done_dly) @(negedge clk);
            cmd_done = 1'b1;
            @(negedge clk); cmd_done = 1'b0;
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("reset_outs", {cmd_req, cmd_type, cmd_addr, wr_flush, frame_valid, ref_overrun}, 0);

    // Single-decision vectors from reset (last grant resets to READ).
    vt[0] = '{wl: 64,   rs: 0,    req: 1, t: 2'b01, a: 24'h000000};
    vt[1] = '{wl: 0,    rs: 64,   req: 1, t: 2'b10, a: 24'h800000};
    vt[2] = '{wl: 63,   rs: 63,   req: 0, t: 2'b00, a: 24'h000000};
    vt[3] = '{wl: 64,   rs: 64,   req: 1, t: 2'b01, a: 24'h000000};
    vt[4] = '{wl: 1023, rs: 63,   req: 1, t: 2'b01, a: 24'h000000};
    vt[5] = '{wl: 63,   rs: 1023, req: 1, t: 2'b10, a: 24'h800000};
    vt[6] = '{wl: 0,    rs: 0,    req: 0, t: 2'b00, a: 24'h000000};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      init_done = 1'b1; wr_level = vt[i].wl; rd_space = vt[i].rs;
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d", i), {cmd_req, cmd_type, cmd_addr}, {vt[i].req, vt[i].t, vt[i].a});
    end

    do_reset();
    wr_level = 64; rd_space = 64;
    repeat (5) @(negedge clk);
    check("no_init_req", cmd_req, 0);

    // Periodic refresh while idle.
    do_reset();
    init_done = 1'b1; ack_en = 1; c0 = cyc;
    repeat (3) exp_q.push_back({2'b00, 24'h0});
    repeat (2400) @(negedge clk);
    check("t1_ref_count", n_sb, 3);
    check("t1_first_ref", ref_t[0] - c0, 781);
    check("t1_ref_gap1", ref_t[1] - ref_t[0], 780);
    check("t1_ref_gap2", ref_t[2] - ref_t[1], 780);
    check("t1_overrun", ref_overrun, 0);

    // Refresh never acked: held stable, overrun on the second wrap.
    do_reset();
    init_done = 1'b1;
    k = 0;
    while (!cmd_req && k < 900) begin @(negedge clk); k++; end
    check("t2_req_seen", cmd_req, 1);
    held = {cmd_type, cmd_addr};
    check("t2_held_cmd", held, 0);
    check("t2_no_overrun_yet", ref_overrun, 0);
    stab_err = 0;
    repeat (1600) begin
      @(negedge clk);
      if ({cmd_req, cmd_type, cmd_addr} !== {1'b1, held}) stab_err++;
    end
    check("t2_stable", stab_err, 0);
    check("t2_overrun", ref_overrun, 1);

    // Round-robin with both sides eligible.
    do_reset();
    init_done = 1'b1; ack_en = 1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b01, 1'b0, 23'(i * 64)});
      exp_q.push_back({2'b10, 1'b1, 23'(i * 64)});
    end
    wr_level = 64; rd_space = 64;
    wait_sb(6, 300, "t3_rr");
    wr_level = 0; rd_space = 0;
    repeat (10) @(negedge clk);
    check("t3_drain", exp_q.size(), 0);

    // Full frame write, stall, frame swap, read from the completed buffer.
    do_reset();
    init_done = 1'b1; ack_en = 1; ign_ref = 1;
    for (int i = 0; i < 4800; i++) exp_q.push_back({2'b01, 1'b0, 23'(i * 64)});
    wr_level = 64;
    wait_sb(4800, 40000, "t4_fill");
    repeat (40) @(negedge clk);
    check("t4_fv_before", frame_valid, 0);
    wr_level = 0;
    repeat (5) @(negedge clk);
    fc0 = flush_cnt;
    pulse_wr();
    repeat (3) @(negedge clk);
    check("t4_fv_after", frame_valid, 1);
    check("t4_flush_pulse", flush_cnt - fc0, 1);
    pulse_rd();
    repeat (3) @(negedge clk);
    exp_q.push_back({2'b10, 24'h000000});
    exp_q.push_back({2'b01, 24'h800000});
    wr_level = 64; rd_space = 64;
    wait_sb(4802, 300, "t4_swap");
    wr_level = 0; rd_space = 0;
    repeat (10) @(negedge clk);
    check("t4_drain", exp_q.size(), 0);

    // Short frame keeps the buffer and frame_valid.
    do_reset();
    init_done = 1'b1; ack_en = 1; ign_ref = 1;
    for (int i = 0; i < 100; i++) exp_q.push_back({2'b01, 1'b0, 23'(i * 64)});
    wr_level = 64;
    wait_sb(100, 2000, "t5_fill");
    wr_level = 0;
    repeat (10) @(negedge clk);
    fc0 = flush_cnt;
    pulse_wr();
    repeat (3) @(negedge clk);
    check("t5_fv", frame_valid, 0);
    check("t5_flush_pulse", flush_cnt - fc0, 1);
    exp_q.push_back({2'b01, 24'h000000});
    wr_level = 64;
    wait_sb(101, 300, "t5_restart");
    wr_level = 0;
    repeat (10) @(negedge clk);
    check("t5_drain", exp_q.size(), 0);

    // Frame start while BUSY: applied only after the burst completes.
    do_reset();
    init_done = 1'b1; ack_en = 1; ign_ref = 1; done_dly = 5;
    exp_q.push_back({2'b01, 24'h000000});
    exp_q.push_back({2'b01, 24'h000040});
    exp_q.push_back({2'b01, 24'h000000});
    wr_level = 64;
    wait_sb(2, 300, "t6_two");
    repeat (2) @(negedge clk);
    fc0 = flush_cnt;
    pulse_wr();
    @(negedge clk);
    check("t6_no_flush_in_busy", flush_cnt - fc0, 0);
    wait_sb(3, 300, "t6_restart");
    wr_level = 0;
    repeat (12) @(negedge clk);
    check("t6_flush_pulse", flush_cnt - fc0, 1);
    check("t6_drain", exp_q.size(), 0);

    // Refresh wrap coinciding with both sides becoming eligible.
    do_reset();
    init_done = 1'b1; ack_en = 1;
    exp_q.push_back({2'b00, 24'h000000});
    exp_q.push_back({2'b01, 24'h000000});
    exp_q.push_back({2'b10, 24'h800000});
    repeat (780) @(posedge clk);
    @(negedge clk);
    wr_level = 64; rd_space = 64;
    wait_sb(3, 300, "t7_order");
    wr_level = 0; rd_space = 0;
    repeat (10) @(negedge clk);
    check("t7_drain", exp_q.size(), 0);
    check("t7_overrun", ref_overrun, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
